nfc_cmd_sequencer: RTL
======================

// Module: nfc_cmd_sequencer
// PURPOSE
//  Host-side front end of the NAND controller: accepts page/block ops on a valid/ready request port, drives the
//  flash_cmd_interface start/cmd/RWA handshake into the NAND core, waits for done, and collects its PErr/EErr/RErr
//  flags into one response per request. Issues a flash RESET after every reset before accepting any request.
//  Retries reads on ECC error and times out hung ops.
// PARAMETERS
//  CMD_RESET    3'b011  core cmd code for flash reset
//  CMD_READ     3'b001  core cmd code for page read
//  CMD_PROG     3'b100  core cmd code for page program
//  CMD_ERASE    3'b010  core cmd code for block erase
//  TIMEOUT_CYC  2**20   cycles allowed from start to done, 1..2**24
//  MAX_RETRY    2       extra attempts for READ on RErr, 0..3
// PORTS
//  clk          in   1   system clock, same as the core's clock
//  rst_n        in   1   synchronous active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   sequencer can take request
//  req_op       in   2   0=RESET 1=READ 2=PROG 3=ERASE
//  req_addr     in   16  row address, placed on fc_rwa
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   host takes response
//  rsp_op       out  2   op echoed from request
//  rsp_status   out  4   {timeout, rerr, eerr, perr}
//  rsp_tries    out  2   attempts used minus 1
//  fc_start     out  1   one-cycle start pulse to core
//  fc_cmd       out  3   core command code
//  fc_rwa       out  16  row/word address to core
//  fc_done      in   1   core done, sticky until next start
//  perr,eerr,rerr in 1   core sticky error flags
//  init_done    out  1   power-up flash RESET has completed
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge) values: all outputs 0, state INIT, retry count 0, timer 0.
//  Reset takes effect mid-op; no response is produced for an op that was in flight.
//  States: INIT, IDLE, ISSUE, GUARD, WAIT, SETTLE, RESP.
//  INIT: load CMD_RESET, rwa=0, go ISSUE. init_done is set when that op leaves SETTLE.
//    That op produces no rsp_valid. init_done stays 1 until rst_n.
//  IDLE: req_ready=1 only here and only if init_done=1.
//    On req_valid&req_ready, latch op/addr, map op to fc_cmd, go ISSUE.
//  ISSUE: fc_start=1 for exactly this cycle. fc_cmd/fc_rwa hold from ISSUE until leaving SETTLE. Timer cleared.
//  GUARD: one cycle, fc_done ignored while the core clears its stale done. Then go WAIT.
//  WAIT: timer +1 per cycle.
//    fc_done=1 -> SETTLE.
//    timer reaches TIMEOUT_CYC-1 with no done -> status.timeout=1, go RESP. No retry after a timeout.
//  SETTLE: one cycle, then sample perr/eerr/rerr into status.
//    If op=READ and rerr=1 and retry count<MAX_RETRY: retry count +1, go ISSUE (same cmd/addr).
//    Otherwise go RESP.
//  RESP: rsp_valid=1 with op/status/tries stable until rsp_ready. Then clear retry count, go IDLE.
//    rsp_valid never drops without rsp_ready.
//  Status from the final attempt only. A successful retry reports status 0 with tries>0.
//  Timer is 24 bits, saturating, never wraps. fc_start never asserts outside ISSUE.
//  req_valid during busy states is ignored (req_ready=0). Requests are not queued.
// TESTING
//  Release rst_n -> exactly one fc_start with fc_cmd=3'b011. No rsp_valid. init_done=1 one cycle after SETTLE.
//  READ addr 16'h1234, core done after 50 cycles, no errs:
//    fc_start once, fc_rwa=16'h1234, rsp status 4'b0000, tries 0.
//  READ with rerr=1 on every attempt, MAX_RETRY=2 -> 3 fc_start pulses, rsp status 4'b0100, tries 2.
//  PROG with core never raising done, TIMEOUT_CYC=100 -> rsp 100 cycles after WAIT entry, status 4'b1000.
//  ERASE with eerr=1 and rsp_ready held low 20 cycles -> rsp_valid/status 4'b0010 stable until handshake.
//    req_ready=0 throughout.
//  rst_n pulsed low during WAIT of a PROG -> no rsp. New INIT reset command issued. Next READ completes normally.

Source files
------------

// File: rtl/nfc_cmd_sequencer.sv
// nfc_cmd_sequencer: host request front end that sequences start/cmd/rwa ops into the NAND core and reports status
module nfc_cmd_sequencer #(
    parameter int TIMEOUT_CYC = 2**20,
    parameter int MAX_RETRY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [15:0] req_addr_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [1:0]  rsp_op_o,
    output logic [3:0]  rsp_status_o,
    output logic [1:0]  rsp_tries_o,
    output logic        fc_start_o,
    output logic [2:0]  fc_cmd_o,
    output logic [15:0] fc_rwa_o,
    input  logic        fc_done_i,
    input  logic        perr_i,
    input  logic        eerr_i,
    input  logic        rerr_i,
    output logic        init_done_o
);
    localparam logic [2:0]  CMD_RESET = 3'b011;
    localparam logic [2:0]  CMD_READ  = 3'b001;
    localparam logic [2:0]  CMD_PROG  = 3'b100;
    localparam logic [2:0]  CMD_ERASE = 3'b010;
    localparam logic [23:0] TMO_LAST  = 24'(TIMEOUT_CYC - 1);
    localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);
    typedef enum logic [2:0] {INIT, IDLE, ISSUE, GUARD, WAIT, SETTLE, RESP} state_t;
    state_t      state_q, state_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [15:0] rwa_q, rwa_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  status_q, status_d;
    logic [1:0]  retry_q, retry_d;
    logic [23:0] timer_q, timer_d;
    logic        init_done_q, init_done_d;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cmd_q       <= '0;
            rwa_q       <= '0;
            op_q        <= '0;
            status_q    <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rwa_q       <= rwa_d;
            op_q        <= op_d;
            status_q    <= status_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            init_done_q <= init_done_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rwa_d       = rwa_q;
        op_d        = op_q;
        status_d    = status_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        init_done_d = init_done_q;
        case (state_q)
            INIT: begin
                cmd_d   = CMD_RESET;
                rwa_d   = '0;
                op_d    = 2'd0;
                retry_d = '0;
                state_d = ISSUE;
            end
            IDLE: begin
                if (req_valid_i && init_done_q) begin
                    op_d    = req_op_i;
                    rwa_d   = req_addr_i;
                    cmd_d   = req_op_i == 2'd0 ? CMD_RESET :
                              req_op_i == 2'd1 ? CMD_READ  :
                              req_op_i == 2'd2 ? CMD_PROG  : CMD_ERASE;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = GUARD;
            end
            GUARD: state_d = WAIT;
            WAIT: begin
                timer_d = &timer_q ? timer_q : timer_q + 24'd1;
                if (fc_done_i) begin
                    state_d = SETTLE;
                end else if (timer_q == TMO_LAST) begin
                    status_d = 4'b1000;
                    // a hung power-up reset is simply reissued; it never produces a response
                    state_d  = init_done_q ? RESP : INIT;
                end
            end
            SETTLE: begin
                status_d = {1'b0, rerr_i, eerr_i, perr_i};
                if (op_q == 2'd1 && rerr_i && retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 2'd1;
                    state_d = ISSUE;
                end else if (!init_done_q) begin
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    retry_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end
    assign req_ready_o  = state_q == IDLE && init_done_q;
    assign rsp_valid_o  = state_q == RESP;
    assign fc_start_o   = state_q == ISSUE;
    assign fc_cmd_o     = cmd_q;
    assign fc_rwa_o     = rwa_q;
    assign rsp_op_o     = op_q;
    assign rsp_status_o = status_q;
    assign rsp_tries_o  = retry_q;
    assign init_done_o  = init_done_q;
endmodule
